// File: rtl/fixdiv_pkg.sv
// rtl/fixdiv_pkg.sv - divider types and width helpers; FIXDIV_ROUND_EN adds the guard-bit iteration
package fixdiv_pkg;
`include "fixpoint_defs.vh"

  typedef enum logic [1:0] {
    IDLE = `FIXDIV_ST_IDLE,
    CALC = `FIXDIV_ST_CALC,
    DONE = `FIXDIV_ST_DONE
  } state_t;

  localparam int DEFAULT_IN_BITS = `FIXDIV_IN_BITS;

  function automatic int frac_bits(input int n);
    return `FIXDIV_FRAC_BITS(n);
  endfunction

  function automatic logic [63:0] max_pos(input int n);
    return `FIXDIV_MAX_POS(n);
  endfunction

  function automatic int iter_count(input int n);
`ifdef FIXDIV_ROUND_EN
    return n;
`else
    return n - 1;
`endif
  endfunction
endpackage

// File: rtl/fixdiv_step.sv
// rtl/fixdiv_step.sv - one restoring shift/subtract step of the magnitude divider
module fixdiv_step #(
  parameter int W = 36
) (
  input  logic [W-1:0] rem,
  input  logic         bit_in,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic         q_bit
);
  logic [W:0]   shifted;
  logic [W-1:0] diff;

  assign shifted  = {rem, bit_in};
  assign q_bit    = (shifted >= {1'b0, divisor});
  // When the subtract succeeds the difference is below the divisor, so W bits hold it.
  assign diff     = shifted[W-1:0] - divisor;
  assign rem_next = q_bit ? diff : shifted[W-1:0];
endmodule

// File: rtl/fixpoint_defs.vh
// rtl/fixpoint_defs.vh - shared fixed-point widths, saturation limit and divider state codes
`ifndef FIXPOINT_DEFS_VH
`define FIXPOINT_DEFS_VH

`define FIXDIV_IN_BITS 37
`define FIXDIV_FRAC_BITS(n) ((n) - 2)
`define FIXDIV_MAX_POS(n) ((64'd1 << ((n) - 1)) - 64'd1)

`define FIXDIV_ST_IDLE 2'd0
`define FIXDIV_ST_CALC 2'd1
`define FIXDIV_ST_DONE 2'd2

`endif

// File: rtl/fixdiv.sv
// rtl/fixdiv.sv - fixed-latency signed fixed-point divider; FIXDIV_ROUND_EN enables round-half-away
module fixdiv
  import fixdiv_pkg::*;
#(
  parameter int IN_BITS = DEFAULT_IN_BITS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_BITS-1:0] a,
  input  logic [IN_BITS-1:0] b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IN_BITS-1:0] result,
  output logic               div_zero,
  output logic               overflow
);
  localparam int FRAC_BITS = frac_bits(IN_BITS);
  localparam int MW        = IN_BITS - 1;
  localparam int ITER      = iter_count(IN_BITS);
  localparam int CW        = $clog2(ITER + 1);
  localparam logic [MW-1:0] MAX_POS = MW'(max_pos(IN_BITS));

  function automatic logic [MW-1:0] mag_of(input logic [IN_BITS-1:0] v);
    logic [IN_BITS-1:0] neg_v;
    neg_v = -v;
    if (!v[IN_BITS-1]) return v[MW-1:0];
    if (v[MW-1:0] == '0) return MAX_POS;
    return neg_v[MW-1:0];
  endfunction

  state_t        state;
  logic [CW-1:0] cnt;
  logic [MW-1:0] mag_a, mag_b, rem;
  logic [ITER-2:0] q;
  logic          neg, a_neg, a_min;

  logic [MW-1:0]   rem_next;
  logic            q_bit, bit_in;
  logic [ITER-1:0] q_full;

  // |a|<<FRAC_BITS split as: high part preloads the remainder, only a[0] remains to shift in.
  assign bit_in = (cnt == '0) ? mag_a[0] : 1'b0;
  assign q_full = {q, q_bit};

  fixdiv_step #(.W(MW)) u_step (
    .rem      (rem),
    .bit_in   (bit_in),
    .divisor  (mag_b),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  logic [MW-1:0]      mag_res;
  logic               neg_res, dz_c, ovf_c;
  logic [IN_BITS-1:0] res_c;
`ifdef FIXDIV_ROUND_EN
  logic [MW:0]        rounded;
`endif

  always_comb begin
    dz_c    = 1'b0;
    ovf_c   = 1'b0;
    neg_res = neg;
    mag_res = '0;
`ifdef FIXDIV_ROUND_EN
    rounded = {1'b0, q_full[ITER-1:1]} + {{MW{1'b0}}, q_full[0]};
`endif
    if (mag_b == '0) begin
      dz_c    = 1'b1;
      neg_res = a_neg;
      mag_res = (mag_a == '0) ? '0 : MAX_POS;
    // The true |a| of the most negative input is one above its saturated magnitude.
    end else if (({1'b0, mag_a} + {{MW{1'b0}}, a_min}) >= {mag_b, 1'b0}) begin
      ovf_c   = 1'b1;
      mag_res = MAX_POS;
    end else begin
`ifdef FIXDIV_ROUND_EN
      if (rounded[MW]) begin
        ovf_c   = 1'b1;
        mag_res = MAX_POS;
      end else begin
        mag_res = rounded[MW-1:0];
      end
`else
      mag_res = q_full[MW-1:0];
`endif
    end
    res_c = neg_res ? (IN_BITS'(0) - {1'b0, mag_res}) : {1'b0, mag_res};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
      mag_a     <= '0;
      mag_b     <= '0;
      rem       <= '0;
      q         <= '0;
      neg       <= 1'b0;
      a_neg     <= 1'b0;
      a_min     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid && in_ready) begin
          mag_a    <= mag_of(a);
          mag_b    <= mag_of(b);
          rem      <= mag_of(a) >> (MW - FRAC_BITS);
          q        <= '0;
          neg      <= a[IN_BITS-1] ^ b[IN_BITS-1];
          a_neg    <= a[IN_BITS-1];
          a_min    <= a[IN_BITS-1] && (a[MW-1:0] == '0);
          cnt      <= '0;
          in_ready <= 1'b0;
          state    <= CALC;
        end
        CALC: begin
          rem <= rem_next;
          q   <= q_full[ITER-2:0];
          cnt <= cnt + 1'b1;
          if (cnt == CW'(ITER - 1)) begin
            cnt       <= '0;
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= res_c;
            div_zero  <= dz_c;
            overflow  <= ovf_c;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fixdiv.sv
// tb/tb_fixdiv.sv - table, corner-sequence and random-vs-model checks of fixdiv
module tb_fixdiv;
  localparam int W = 37;
  localparam int FRAC = 35;
  localparam longint MAXP = (64'sd1 <<< 36) - 1;
`ifdef FIXDIV_ROUND_EN
  localparam int ITER = 37;
`else
  localparam int ITER = 36;
`endif

  logic clk = 0, reset = 1, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, div_zero, overflow;
  logic [W-1:0] a = '0, b = '0, result;
  int ntests = 0, nfail = 0;

  fixdiv dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .div_zero(div_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint a, b, res;
    logic   dz, ov;
  } vec_t;

  function automatic logic [W-1:0] mk(input longint v);
    return v[W-1:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: real-valued division of the magnitudes with the output rules applied.
  function automatic void model(input logic signed [W-1:0] ta, input logic signed [W-1:0] tb,
                                output logic [W-1:0] r, output logic dz, output logic ov);
    longint sa, sb, true_a, ma, mb, mag, res;
    logic [127:0] num, qq;
    logic neg;
    sa = ta; sb = tb;
    true_a = (sa < 0) ? -sa : sa;
    ma = (true_a > MAXP) ? MAXP : true_a;
    mb = (sb < 0) ? -sb : sb;
    if (mb > MAXP) mb = MAXP;
    dz = 0; ov = 0;
    neg = (sa < 0) != (sb < 0);
    if (sb == 0) begin
      dz = 1; neg = sa < 0; mag = (sa == 0) ? 0 : MAXP;
    end else if (true_a >= 2 * mb) begin
      ov = 1; mag = MAXP;
    end else begin
      num = 128'(ma) << FRAC;
`ifdef FIXDIV_ROUND_EN
      qq = (2 * num + 128'(mb)) / (2 * 128'(mb));
`else
      qq = num / 128'(mb);
`endif
      if (qq > 128'(MAXP)) begin ov = 1; mag = MAXP; end
      else mag = longint'(qq);
    end
    res = neg ? -mag : mag;
    r = res[W-1:0];
  endfunction

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input int hold,
                        output logic [W-1:0] r, output logic dz, output logic ov, output int lat);
    int n;
    logic [63:0] junk;
    @(negedge clk);
    a = ta; b = tb; in_valid = 1;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    in_valid = 0;
    junk = {$urandom, $urandom};
    a = junk[W-1:0]; b = junk[63:27];
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    r = result; dz = div_zero; ov = overflow;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_result", result, r);
      check("hold_in_ready", in_ready, 0);
      check("hold_out_valid", out_valid, 1);
    end
    @(negedge clk); out_ready = 1;
    @(posedge clk); #1; out_ready = 0;
    check("post_handshake_out_valid", out_valid, 0);
  endtask

  vec_t tbl[10];
  logic [W-1:0] r, er;
  logic dz, ov, edz, eov;
  int lat;
  logic signed [W-1:0] ra, rb;
  logic [63:0] t;

  initial begin
    tbl[0] = '{64'sd1 <<< 34, 64'sd1 <<< 35, 64'sd1 <<< 34, 0, 0};
    tbl[1] = '{-(64'sd3 <<< 33), 64'sd1 <<< 34, -(64'sd3 <<< 34), 0, 0};
    tbl[2] = '{64'sd1 <<< 35, 64'sd1 <<< 33, MAXP, 0, 1};
    tbl[3] = '{-(64'sd1 <<< 36), 64'sd1 <<< 35, -MAXP, 0, 1};
    tbl[4] = '{-(64'sd1 <<< 34), 0, -MAXP, 1, 0};
    tbl[5] = '{0, 0, 0, 1, 0};
`ifdef FIXDIV_ROUND_EN
    tbl[6] = '{1, 64'sd3 <<< 34, 1, 0, 0};
    tbl[9] = '{-1, MAXP, -1, 0, 0};
`else
    tbl[6] = '{1, 64'sd3 <<< 34, 0, 0, 0};
    tbl[9] = '{-1, MAXP, 0, 0, 0};
`endif
    tbl[7] = '{-(64'sd1 <<< 36), -(64'sd1 <<< 36), 64'sd1 <<< 35, 0, 0};
    tbl[8] = '{64'sd1 <<< 35, -(64'sd1 <<< 35), -(64'sd1 <<< 35), 0, 0};

    repeat (3) @(posedge clk);
    @(negedge clk); reset = 0;
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_result", result, 0);
    check("reset_div_zero", div_zero, 0);
    check("reset_overflow", overflow, 0);

    for (int i = 0; i < 10; i++) begin
      run_op(mk(tbl[i].a), mk(tbl[i].b), 0, r, dz, ov, lat);
      check($sformatf("tbl%0d_result", i), r, mk(tbl[i].res));
      check($sformatf("tbl%0d_div_zero", i), dz, tbl[i].dz);
      check($sformatf("tbl%0d_overflow", i), ov, tbl[i].ov);
      check($sformatf("tbl%0d_latency", i), lat, ITER);
    end

    run_op(mk(-(64'sd3 <<< 33)), mk(64'sd1 <<< 34), 5, r, dz, ov, lat);
    check("hold_op_result", r, mk(-(64'sd3 <<< 34)));

    @(negedge clk); a = mk(64'sd1 <<< 35); b = mk(64'sd1 <<< 34); in_valid = 1;
    @(posedge clk); #1; in_valid = 0;
    repeat (10) @(posedge clk);
    @(negedge clk); reset = 1;
    @(posedge clk); #1; reset = 0;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_result", result, 0);
    repeat (ITER + 5) @(posedge clk);
    #1 check("abort_no_late_valid", out_valid, 0);
    run_op(mk(64'sd1 <<< 34), mk(64'sd1 <<< 35), 0, r, dz, ov, lat);
    check("after_abort_result", r, mk(64'sd1 <<< 34));
    check("after_abort_latency", lat, ITER);

    for (int i = 0; i < 150; i++) begin
      t = {$urandom, $urandom}; ra = t[W-1:0];
      t = {$urandom, $urandom}; rb = t[W-1:0];
      ra = ra >>> $urandom_range(0, 36);
      rb = rb >>> $urandom_range(0, 36);
      if ($urandom_range(0, 15) == 0) rb = '0;
      model(ra, rb, er, edz, eov);
      run_op(ra, rb, 0, r, dz, ov, lat);
      check($sformatf("rnd%0d_result a=%0h b=%0h", i, ra, rb), r, er);
      check($sformatf("rnd%0d_flags", i), {dz, ov}, {edz, eov});
      check($sformatf("rnd%0d_latency", i), lat, ITER);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/fixdiv.md
FIXDIV -- requirements
Module: fixdiv

Interface
REQ-001 SHALL have parameter IN_BITS, default 37, total two's-complement width of a, b, result.
REQ-002 SHALL derive FRAC_BITS = IN_BITS-2, giving 1 sign bit, 1 integer bit and range (-2,2); FRAC_BITS is not overridable.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  dividend and divisor present.
REQ-006 in_ready  output  1  block can accept an operand pair.
REQ-007 a  input  IN_BITS  signed dividend.
REQ-008 b  input  IN_BITS  signed divisor.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  IN_BITS  signed quotient a/b.
REQ-012 div_zero  output  1  b was zero.
REQ-013 overflow  output  1  |a/b| >= 2, or rounding overflowed; result saturated.

Function
REQ-014 SHALL use states IDLE, CALC, DONE: IDLE->CALC on in_valid&&in_ready; CALC->DONE after ITER cycles; DONE->IDLE on out_valid&&out_ready.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 SHALL register a and b on the accepting edge; later input changes have no effect.
REQ-017 SHALL divide magnitudes: sign = a[MSB]^b[MSB]; magnitude = IN_BITS-1 bits; the most negative input (-2^(IN_BITS-1)) SHALL be taken as magnitude 2^(IN_BITS-1)-1.
REQ-018 SHALL compute one quotient bit per CALC cycle by restoring shift/subtract of |a|<<FRAC_BITS by |b|; ITER = IN_BITS-1.
REQ-019 Latency SHALL be fixed: out_valid rises exactly ITER edges after the accepting edge, including for div-by-zero and overflow cases.
REQ-020 Without rounding, the quotient magnitude SHALL truncate toward zero.
REQ-021 If |b|!=0 and |a| >= 2|b|, overflow SHALL be 1 and result SHALL be +MAX_POS or -MAX_POS per sign, with MAX_POS = 2^(IN_BITS-1)-1.
REQ-022 If b==0, div_zero SHALL be 1, overflow 0, and result SHALL be ±MAX_POS with the sign of a, or 0 if a==0.
REQ-023 A zero quotient SHALL be output as all-zero regardless of sign.
REQ-024 result, div_zero and overflow SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 The DONE->IDLE handshake and a new in_valid SHALL NOT overlap: in_ready rises the cycle after the output handshake.

Reset
REQ-026 reset SHALL force IDLE: in_ready=1, out_valid=0, result=0, div_zero=0, overflow=0, iteration counter=0.
REQ-027 reset asserted in CALC or DONE SHALL abort the operation with no output handshake; reset has priority over all handshakes.

Configuration
REQ-028 Macro FIXDIV_ROUND_EN, when defined, SHALL add one iteration (ITER = IN_BITS) to produce a guard bit and round half away from zero on magnitude; if rounding exceeds MAX_POS, the block SHALL clamp to MAX_POS and set overflow.
REQ-029 Without FIXDIV_ROUND_EN, ITER = IN_BITS-1 and results SHALL truncate per REQ-020.

Structure
REQ-030 Shared header fixpoint_defs.vh SHALL hold the default IN_BITS, the FRAC_BITS derivation, the MAX_POS expression and the state encodings IDLE/CALC/DONE.
REQ-031 The block SHALL instantiate one combinational sub-module, fixdiv_step, that performs one restoring subtract and returns the next partial remainder and quotient bit.

Verification (IN_BITS=37, 1.0 = 2^35)
REQ-032 a=2^34 (0.5), b=2^35 (1.0) -> result=2^34, flags 0, out_valid exactly 36 edges after accept.
REQ-033 a=-(3*2^33) (-0.75), b=2^34 (0.5) -> result=-(3*2^34) (-1.5), flags 0.
REQ-034 a=2^35, b=2^33 (1.0/0.25) -> overflow=1, result=2^36-1; a=-2^36, b=2^35 -> overflow=1, result=-(2^36-1).
REQ-035 a=-2^34, b=0 -> div_zero=1, result=-(2^36-1); a=0, b=0 -> div_zero=1, result=0.
REQ-036 Hold out_ready=0 for 5 cycles in DONE -> result stable, in_ready=0; assert reset 10 cycles into CALC -> IDLE, out_valid=0, next operation correct.
REQ-037 a=1, b=3*2^34 -> result=0 without FIXDIV_ROUND_EN (latency 36); result=1 with it (latency 37).
